dmem_sram_responder: RTL and testbench



---
 rtl/dmem_sram_responder_pkg.sv | 19 +
 rtl/dmem_sram_responder_wait_counter.sv | 22 ++
 rtl/dmem_sram_responder.sv | 94 +++++++++
 tb/tb_dmem_sram_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_sram_responder_pkg.sv
// Shared types and limits for the data-memory SRAM responder.
// The FSM state encoding and the wait-counter width live here.
package dmem_sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int CNT_W    = 4;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_sram_responder_wait_counter.sv
// Strobe-active cycle counter; terminal flags the last SRAM access cycle.
module wait_counter
  import dmem_sram_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic terminal
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else                count <= count + 1'b1;
  end

  assign terminal = (count == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/dmem_sram_responder.sv
// Data-port responder: turns single-cycle load/store requests into multi-cycle
// asynchronous SRAM accesses, stalling the core until the DONE cycle.
module dmem_sram_responder
  import dmem_sram_responder_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic [31:0]          read_data,
  output logic                 stall,
  output logic                 addr_err,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [31:0]          sram_wdata,
  output logic                 sram_wdata_en,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n,
  input  logic [31:0]          sram_rdata
);

  state_t state, state_next;
  logic   req, aligned, accept, terminal, count_clear;
  logic   op_write, access_next, write_next;
  logic   addr_unused;

  assign req         = mem_read | mem_write;
  assign aligned     = word_aligned(addr[1:0]);
  assign accept      = (state == IDLE) && req && aligned;
  assign count_clear = (state != ACCESS);
  // High address bits alias onto the same SRAM word by design.
  assign addr_unused = ^addr[31:ADDR_BITS+2];

  wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .clear    (count_clear),
    .terminal (terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACCESS;
      ACCESS:  if (terminal) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered, so they are computed from the state being entered.
  always_comb begin
    stall       = accept || (state == ACCESS);
    access_next = (state_next == ACCESS);
    write_next  = (state == IDLE) ? mem_write : op_write;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_write      <= 1'b0;
      sram_addr     <= '0;
      sram_wdata    <= '0;
      read_data     <= '0;
      addr_err      <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_wdata_en <= 1'b0;
    end else begin
      if (accept) begin
        op_write   <= mem_write;
        sram_addr  <= addr[ADDR_BITS+1:2];
        sram_wdata <= write_data;
      end
      if ((state == ACCESS) && terminal && !op_write) read_data <= sram_rdata;
      addr_err      <= (state == IDLE) && req && !aligned;
      sram_ce_n     <= !access_next;
      sram_oe_n     <= !(access_next && !write_next);
      sram_we_n     <= !(access_next && write_next);
      sram_wdata_en <= access_next && write_next;
    end
  end

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Randomized bench for dmem_sram_responder at WAIT_CYCLES of 2, 1 and 15,
// against a word-level memory model and an async SRAM device model.
module tb_dmem_sram_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr       [N];
  logic [31:0] write_data [N];
  logic        mem_read   [N];
  logic        mem_write  [N];
  logic [31:0] read_data  [N];
  logic        stall      [N];
  logic        addr_err   [N];
  logic [15:0] sram_addr  [N];
  logic [31:0] sram_wdata [N];
  logic        wdata_en   [N];
  logic        ce_n       [N];
  logic        oe_n       [N];
  logic        we_n       [N];
  logic [31:0] sram_rdata [N];

  int checks   = 0;
  int failures = 0;
  int cycle_cnt = 0;

  logic [31:0] ref_mem [N][1024];
  logic [31:0] exp_rd  [N];

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic int wc(int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 15);
  endfunction

  for (genvar g = 0; g < N; g++) begin : gen_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    logic [31:0] mem [1024];
    int          wcnt = 0;
    logic [15:0] wa;
    logic [31:0] wd;

    dmem_sram_responder #(.WAIT_CYCLES(W), .ADDR_BITS(16)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .addr          (addr[g]),
      .write_data    (write_data[g]),
      .mem_read      (mem_read[g]),
      .mem_write     (mem_write[g]),
      .read_data     (read_data[g]),
      .stall         (stall[g]),
      .addr_err      (addr_err[g]),
      .sram_addr     (sram_addr[g]),
      .sram_wdata    (sram_wdata[g]),
      .sram_wdata_en (wdata_en[g]),
      .sram_ce_n     (ce_n[g]),
      .sram_oe_n     (oe_n[g]),
      .sram_we_n     (we_n[g]),
      .sram_rdata    (sram_rdata[g])
    );

    assign sram_rdata[g] = (!ce_n[g] && !oe_n[g]) ? mem[sram_addr[g][9:0]] : 32'hBAD0_BAD0;

    // A write lands only after a full-width WE pulse with address/data held a cycle past it.
    always @(posedge clk) begin
      if (!ce_n[g] && !we_n[g]) begin
        wcnt <= wcnt + 1;
        wa   <= sram_addr[g];
        wd   <= sram_wdata[g];
      end else begin
        if (wcnt == W && sram_addr[g] == wa && sram_wdata[g] == wd) mem[wa[9:0]] <= wd;
        wcnt <= 0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drop(input int g);
    mem_read[g]  = 1'b0;
    mem_write[g] = 1'b0;
  endtask

  // One core memory instruction; returns at the start of the cycle after it retires.
  task automatic access(input int g, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wdat);
    int          w     = wc(g);
    bit          is_wr = wr;
    bit          is_rd = rd && !wr;
    logic [15:0] word  = a[17:2];
    mem_read[g]   = rd;
    mem_write[g]  = wr;
    addr[g]       = a;
    write_data[g] = wdat;
    if (a[1:0] != 2'b00) begin
      @(negedge clk);
      check_val("mis_req", {26'd0, stall[g], ce_n[g], oe_n[g], we_n[g], wdata_en[g], addr_err[g]}, 32'b0_111_0_0);
      cyc();
      drop(g);
      @(negedge clk);
      check_val("mis_err", {26'd0, addr_err[g], stall[g], ce_n[g], oe_n[g], we_n[g], wdata_en[g]}, 32'b1_0_111_0);
      check_val("mis_rd", read_data[g], exp_rd[g]);
      cyc();
      @(negedge clk);
      check_val("mis_clr", {31'd0, addr_err[g]}, 32'd0);
      cyc();
      return;
    end
    for (int i = 0; i <= w + 1; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check_val("req", {27'd0, stall[g], ce_n[g], oe_n[g], we_n[g], wdata_en[g]}, 32'b1_111_0);
      end else if (i <= w) begin
        check_val("acc", {27'd0, stall[g], ce_n[g], oe_n[g], we_n[g], wdata_en[g]},
                  {27'd0, 1'b1, 1'b0, !is_rd, !is_wr, is_wr});
        check_val("acc_addr", {16'd0, sram_addr[g]}, {16'd0, word});
        if (is_wr) check_val("acc_wd", sram_wdata[g], wdat);
      end else begin
        if (is_rd) exp_rd[g] = ref_mem[g][a[11:2]];
        check_val("done", {27'd0, stall[g], ce_n[g], oe_n[g], we_n[g], wdata_en[g]}, 32'b0_111_0);
        check_val("done_addr", {16'd0, sram_addr[g]}, {16'd0, word});
        if (is_wr) check_val("done_wd", sram_wdata[g], wdat);
        check_val("done_rd", read_data[g], exp_rd[g]);
      end
      cyc();
    end
    if (is_wr) ref_mem[g][a[11:2]] = wdat;
    drop(g);
  endtask

  initial begin
    logic [31:0] tmp, a, d;
    int          c0, kind;
    reset = 1'b1;
    for (int g = 0; g < N; g++) begin
      addr[g] = '0; write_data[g] = '0; drop(g); exp_rd[g] = '0;
    end
    repeat (3) cyc();
    for (int g = 0; g < N; g++) begin
      @(negedge clk);
      check_val("rst_ctl", {26'd0, stall[g], ce_n[g], oe_n[g], we_n[g], wdata_en[g], addr_err[g]}, 32'b0_111_0_0);
      check_val("rst_rd", read_data[g], 32'd0);
      check_val("rst_addr", {16'd0, sram_addr[g]}, 32'd0);
      check_val("rst_wd", sram_wdata[g], 32'd0);
    end
    cyc();
    reset = 1'b0;
    cyc();

    for (int g = 0; g < N; g++)
      for (int k = 0; k < 16; k++) access(g, 1'b0, 1'b1, k * 4, $urandom());

    access(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check_val("load_deadbeef", read_data[0], 32'hDEAD_BEEF);
    access(0, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    cyc();
    check_val("sram_holds", gen_dut[0].mem[8], 32'h1234_5678);
    access(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0);

    d = $urandom();
    c0 = cycle_cnt;
    access(0, 1'b0, 1'b1, 32'h0000_0040, d);
    access(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check_val("b2b_cycles", cycle_cnt - c0, 32'd8);
    check_val("b2b_data", read_data[0], d);

    // Abandoned write: reset lands in the second strobe cycle.
    access(0, 1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_0001);
    mem_write[0] = 1'b1; addr[0] = 32'h0000_0080; write_data[0] = 32'h5555_AAAA;
    @(negedge clk);
    check_val("rw_req", {31'd0, stall[0]}, 32'd1);
    cyc();
    @(negedge clk);
    check_val("rw_acc1", {30'd0, ce_n[0], we_n[0]}, 32'd0);
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check_val("rw_acc2", {29'd0, stall[0], ce_n[0], we_n[0]}, 32'b100);
    cyc();
    reset = 1'b0;
    drop(0);
    for (int g = 0; g < N; g++) exp_rd[g] = '0;
    @(negedge clk);
    check_val("rw_strobes", {27'd0, stall[0], ce_n[0], oe_n[0], we_n[0], wdata_en[0]}, 32'b0_111_0);
    check_val("rw_rd", read_data[0], 32'd0);
    check_val("rw_addr", {16'd0, sram_addr[0]}, 32'd0);
    cyc();
    cyc();
    access(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    check_val("rw_unchanged", read_data[0], 32'hCAFE_0001);

    for (int g = 0; g < N; g++) begin
      for (int t = 0; t < 30; t++) begin
        tmp  = $urandom();
        a    = {tmp[31:18], 12'd0, tmp[3:0], 2'b00};
        d    = $urandom();
        kind = $urandom_range(0, 5);
        case (kind)
          0, 4: access(g, 1'b1, 1'b0, a, d);
          1:    access(g, 1'b0, 1'b1, a, d);
          2:    access(g, 1'b1, 1'b1, a, d);
          3: begin
            a[1:0] = 2'($urandom_range(1, 3));
            access(g, tmp[4], !tmp[4], a, d);
          end
          default: begin
            repeat ($urandom_range(1, 2)) begin
              @(negedge clk);
              check_val("idle", {26'd0, stall[g], ce_n[g], oe_n[g], we_n[g], wdata_en[g], addr_err[g]}, 32'b0_111_0_0);
              cyc();
            end
          end
        endcase
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
